// File: rtl/cdc_pkg.sv
// Shared types and constants for the req/ack CDC handshake receiver.
package cdc_pkg;

    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    typedef enum logic [2:0] {
        WAIT_LOW = 3'd0,
        IDLE     = 3'd1,
        CAPTURE  = 3'd2,
        DELIVER  = 3'd3,
        ACK_HI   = 3'd4
    } cdc_state_e;

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer with a selectable reset value; q_o is the last stage.
module sync_bit #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] stages_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages_q <= {N{RST_VAL}};
        end else begin
            stages_q <= {stages_q[N-2:0], d_i};
        end
    end

    assign q_o = stages_q[N-1];

endmodule

// File: rtl/cdc_handshake_rx.sv
// Responder end of a four-phase req/ack crossing: synchronizes req, captures the word,
// offers it downstream on valid/ready and returns ack as a registered level.
module cdc_handshake_rx
    import cdc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 3,
    parameter bit EARLY_ACK   = 1'b0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             req_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_out,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [CNT_W-1:0] o_count,
    output logic             busy,
    output cdc_state_e       dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    generate
        if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
            $error("cdc_handshake_rx: SYNC_STAGES out of range");
        end
    endgenerate

    logic             req_s;
    logic             accept;
    cdc_state_e       state_q;
    logic             ack_q;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] count_q;

    // Preset to 1 so a req already high at reset looks "still high" and must be seen low first.
    sync_bit #(
        .N       (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (reset_l),
        .d_i   (req_in),
        .q_o   (req_s)
    );

    // Downstream valid/ready: a word transfers on every cycle with o_valid && o_ready;
    // o_data is held while o_valid is high and o_ready is low, o_valid drops the cycle after transfer.
    assign accept = valid_q && o_ready;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= WAIT_LOW;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b0;
                count_q <= count_q + CNT_ONE;
            end
            case (state_q)
                WAIT_LOW: begin
                    ack_q <= 1'b0;
                    if (!req_s) state_q <= IDLE;
                end
                IDLE: begin
                    if (req_s && (!valid_q || accept)) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    // Overrides the accept clear above when a new word lands on the acceptance cycle.
                    data_q  <= data_in;
                    valid_q <= 1'b1;
                    if (EARLY_ACK) begin
                        ack_q   <= 1'b1;
                        state_q <= ACK_HI;
                    end else begin
                        state_q <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (accept) begin
                        ack_q   <= 1'b1;
                        state_q <= ACK_HI;
                    end
                end
                ACK_HI: begin
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= WAIT_LOW;
                end
            endcase
        end
    end

    assign ack_out   = ack_q;
    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_count   = count_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed bench for cdc_handshake_rx: instance A (EARLY_ACK=0, CNT_W=16), instance B (EARLY_ACK=1, CNT_W=4).
module tb_cdc_handshake_rx;
  import cdc_pkg::*;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  int   cyc = 0;

  logic req_a = 1'b0, rdy_a = 1'b0;
  logic [31:0] data_a = '0;
  logic ack_a, valid_a, busy_a;
  logic [31:0] odata_a;
  logic [15:0] cnt_a;
  cdc_state_e st_a;

  logic req_b = 1'b0, rdy_b = 1'b0;
  logic [31:0] data_b = '0;
  logic ack_b, valid_b, busy_b;
  logic [31:0] odata_b;
  logic [3:0] cnt_b;
  cdc_state_e st_b;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cdc_handshake_rx #(.WIDTH(32), .SYNC_STAGES(3), .EARLY_ACK(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .reset_l(reset_l), .req_in(req_a), .data_in(data_a), .ack_out(ack_a),
    .o_data(odata_a), .o_valid(valid_a), .o_ready(rdy_a), .o_count(cnt_a),
    .busy(busy_a), .dbg_state(st_a)
  );

  cdc_handshake_rx #(.WIDTH(32), .SYNC_STAGES(3), .EARLY_ACK(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .reset_l(reset_l), .req_in(req_b), .data_in(data_b), .ack_out(ack_b),
    .o_data(odata_b), .o_valid(valid_b), .o_ready(rdy_b), .o_count(cnt_b),
    .busy(busy_b), .dbg_state(st_b)
  );

  task automatic do_reset;
    @(negedge clk);
    reset_l = 1'b0;
    req_a = 1'b0; req_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Sender plus always-ready sink for instance A; returns words seen and the last one.
  task automatic run_hs_a(input logic [31:0] d, input int max_cyc,
                          output int n, output logic [31:0] w, output bit to);
    bit got_ack = 1'b0;
    n = 0; w = '0; to = 1'b1;
    data_a = d; req_a = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (valid_a && rdy_a) begin n++; w = odata_a; end
      if (ack_a && !got_ack) begin got_ack = 1'b1; req_a = 1'b0; end
      else if (got_ack && !ack_a) begin to = 1'b0; break; end
    end
    req_a = 1'b0;
  endtask

  task automatic run_hs_b(input logic [31:0] d, input int max_cyc,
                          output int n, output logic [31:0] w, output bit to);
    bit got_ack = 1'b0;
    n = 0; w = '0; to = 1'b1;
    data_b = d; req_b = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (valid_b && rdy_b) begin n++; w = odata_b; end
      if (ack_b && !got_ack) begin got_ack = 1'b1; req_b = 1'b0; end
      else if (got_ack && !ack_b) begin to = 1'b0; break; end
    end
    req_b = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack_a); end
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
    n_checks++; if (odata_a !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", odata_a); end
    n_checks++; if (cnt_a !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cnt_a); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy_a); end
    n_checks++; if (st_a !== WAIT_LOW) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", st_a, WAIT_LOW); end
    n_checks++; if (cnt_b !== 4'h0) begin n_fail++; $display("FAIL reset_count_b: got %0d expected 0", cnt_b); end
    @(negedge clk);
    reset_l = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if (st_a !== IDLE) begin n_fail++; $display("FAIL reset_to_idle: got %0d expected %0d", st_a, IDLE); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy_a); end
  endtask

  task automatic test_single;
    do_reset;
    data_a = 32'hDEADBEEF; rdy_a = 1'b1; req_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL single_early_valid edge %0d: got %b expected 0", i, valid_a); end
    end
    @(negedge clk);
    n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", valid_a); end
    n_checks++; if (odata_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h expected deadbeef", odata_a); end
    n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL single_ack_early: got %b expected 0", ack_a); end
    @(negedge clk);
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b expected 0", valid_a); end
    n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL single_ack_rise: got %b expected 1", ack_a); end
    n_checks++; if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", cnt_a); end
    req_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL single_ack_hold %0d: got %b expected 1", i, ack_a); end
    end
    @(negedge clk);
    n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL single_ack_fall: got %b expected 0", ack_a); end
    n_checks++; if (st_a !== IDLE) begin n_fail++; $display("FAIL single_end_state: got %0d expected %0d", st_a, IDLE); end
  endtask

  task automatic test_req_over_reset;
    int n; logic [31:0] w; bit to;
    @(negedge clk);
    reset_l = 1'b0; req_a = 1'b1; data_a = 32'hBAD0BAD0; rdy_a = 1'b1;
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL held_req_valid %0d: got %b expected 0", i, valid_a); end
      n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL held_req_ack %0d: got %b expected 0", i, ack_a); end
    end
    n_checks++; if (st_a !== WAIT_LOW) begin n_fail++; $display("FAIL held_req_state: got %0d expected %0d", st_a, WAIT_LOW); end
    req_a = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (st_a !== IDLE) begin n_fail++; $display("FAIL held_req_idle: got %0d expected %0d", st_a, IDLE); end
    run_hs_a(32'h1, 40, n, w, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL held_req_hs_timeout: got timeout expected completion"); end
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL held_req_words: got %0d expected 1", n); end
    n_checks++; if (w !== 32'h1) begin n_fail++; $display("FAIL held_req_word: got %h expected 1", w); end
  endtask

  task automatic test_stall;
    bit to = 1'b1;
    do_reset;
    data_a = 32'hA5A50003; rdy_a = 1'b0; req_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_a) begin to = 1'b0; break; end
    end
    n_checks++; if (to) begin n_fail++; $display("FAIL stall_valid_timeout: got 0 expected 1"); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL stall_valid %0d: got %b expected 1", i, valid_a); end
      n_checks++; if (odata_a !== 32'hA5A50003) begin n_fail++; $display("FAIL stall_data %0d: got %h expected a5a50003", i, odata_a); end
      n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL stall_ack %0d: got %b expected 0", i, ack_a); end
    end
    rdy_a = 1'b1;
    @(negedge clk);
    n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL stall_ack_rise: got %b expected 1", ack_a); end
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL stall_valid_drop: got %b expected 0", valid_a); end
    req_a = 1'b0; rdy_a = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ack_a) begin to = 1'b0; break; end
    end
    n_checks++; if (to) begin n_fail++; $display("FAIL stall_ack_fall_timeout: got 1 expected 0"); end
    n_checks++; if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL stall_count: got %0d expected 1", cnt_a); end
  endtask

  task automatic test_back_to_back;
    int n_got = 0;
    int ack_cyc[8];
    int acc_cyc[8];
    bit sender_to = 1'b0;
    do_reset;
    exp_q.delete();
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          bit seen = 1'b0;
          data_b = k; exp_q.push_back(k); req_b = 1'b1;
          for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ack_b) begin seen = 1'b1; ack_cyc[k] = cyc; break; end
          end
          req_b = 1'b0;
          if (!seen) begin sender_to = 1'b1; break; end
          seen = 1'b0;
          for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!ack_b) begin seen = 1'b1; break; end
          end
          if (!seen) begin sender_to = 1'b1; break; end
        end
      end
      begin
        for (int c = 0; c < 3000 && n_got < 8; c++) begin
          @(negedge clk);
          rdy_b = 1'($urandom_range(0, 1));
          if (valid_b && rdy_b) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL b2b_extra_word: got %h expected none", odata_b);
            end else begin
              logic [31:0] e = exp_q.pop_front();
              if (odata_b !== e) begin n_fail++; $display("FAIL b2b_word %0d: got %h expected %h", n_got, odata_b, e); end
            end
            acc_cyc[n_got] = cyc;
            n_got++;
          end
        end
      end
    join
    n_checks++; if (sender_to) begin n_fail++; $display("FAIL b2b_sender_timeout: got timeout expected completion"); end
    n_checks++; if (n_got !== 8) begin n_fail++; $display("FAIL b2b_count_words: got %0d expected 8", n_got); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d expected 0", exp_q.size()); end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (ack_cyc[k] > acc_cyc[k]) begin n_fail++; $display("FAIL b2b_ack_order %0d: ack cycle %0d accept cycle %0d", k, ack_cyc[k], acc_cyc[k]); end
    end
    n_checks++; if (cnt_b !== 4'd8) begin n_fail++; $display("FAIL b2b_o_count: got %0d expected 8", cnt_b); end
    rdy_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL b2b_dup_word %0d: got valid %b expected 0", i, valid_b); end
    end
  endtask

  task automatic test_count_wrap;
    int n; logic [31:0] w; bit to;
    do_reset;
    rdy_b = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      logic [3:0] e = 4'(t);
      run_hs_b(32'h100 + t, 60, n, w, to);
      n_checks++; if (to || n !== 1) begin n_fail++; $display("FAIL wrap_hs %0d: got %0d words timeout %b expected 1 word", t, n, to); end
      n_checks++; if (cnt_b !== e) begin n_fail++; $display("FAIL wrap_count %0d: got %0d expected %0d", t, cnt_b, e); end
    end
  endtask

  task automatic test_reset_mid;
    int n; logic [31:0] w; bit to = 1'b1;
    do_reset;
    data_a = 32'h0BADF00D; rdy_a = 1'b0; req_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_a) begin to = 1'b0; break; end
    end
    n_checks++; if (to) begin n_fail++; $display("FAIL mid_valid_timeout: got 0 expected 1"); end
    n_checks++; if (st_a !== DELIVER) begin n_fail++; $display("FAIL mid_state_deliver: got %0d expected %0d", st_a, DELIVER); end
    reset_l = 1'b0;
    #1;
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL mid_valid_clear: got %b expected 0", valid_a); end
    n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL mid_ack_clear: got %b expected 0", ack_a); end
    n_checks++; if (st_a !== WAIT_LOW) begin n_fail++; $display("FAIL mid_state: got %0d expected %0d", st_a, WAIT_LOW); end
    @(negedge clk);
    reset_l = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (st_a !== WAIT_LOW) begin n_fail++; $display("FAIL mid_wait_low: got %0d expected %0d", st_a, WAIT_LOW); end
    req_a = 1'b0;
    repeat (6) @(negedge clk);
    rdy_a = 1'b1;
    run_hs_a(32'h12345678, 40, n, w, to);
    n_checks++; if (to || n !== 1) begin n_fail++; $display("FAIL mid_new_hs: got %0d words timeout %b expected 1 word", n, to); end
    n_checks++; if (w !== 32'h12345678) begin n_fail++; $display("FAIL mid_new_word: got %h expected 12345678", w); end
    n_checks++; if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL mid_count: got %0d expected 1", cnt_a); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_req_over_reset;
    test_stall;
    test_back_to_back;
    test_count_wrap;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
